round_referee: RTL and testbench

- Round-control stage between the player inputs (SW choice, KEY start) and the display consumers: HEX score decoders and the VGA choice renderer.
- On each debounced start press, latches the user and computer choices and judges the round.
- Updates two-digit BCD scores and outcome flags, notifies the computer-strategy block of the played combination, and handshakes a redraw request to the screen stage.

---
 rtl/round_referee.sv | 240 ++++++++++++++++++++++++
 tb/tb_round_referee.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_referee.sv
// round_referee -- round-control stage for the rock/scissor/paper game.
//
// Conditions the raw start key (synchronizer + debounce). On each debounced
// press it latches the user and computer choices, judges the round, updates
// the two-digit BCD scores and outcome flags, and requests a redraw from the
// screen stage. The redraw request is held until the screen stage reports
// that the frame write is complete.
//
// Optional feature macro: MATCH_LIMIT_EN
//   When defined, adds parameter WIN_TARGET and output match_over. match_over
//   is a sticky flag that is set when a winner's score reaches WIN_TARGET.
//   While it is set, new presses are ignored.
//
// Ports:
//   CLOCK_50     in   system clock, 50 MHz
//   reset_n      in   asynchronous active-low reset
//   start_n      in   raw start key, active low, asynchronous to CLOCK_50
//   user_choice  in   [1:0] 00 rock, 01 scissor, 10 paper, 11 invalid
//   com_choice   in   [1:0] computer choice, same encoding
//   draw_done    in   one-cycle pulse when the frame write completes
//   draw_req     out  redraw request, held high until draw_done
//   draw_user    out  [1:0] latched user choice
//   draw_com     out  [1:0] latched computer choice
//   user_score   out  [7:0] BCD score, [7:4] tens and [3:0] units
//   com_score    out  [7:0] BCD score, same layout
//   uwin/cwin/equ out outcome of the last valid round (one-hot or all zero)
//   round_valid  out  one-cycle pulse when a valid round is judged
//   combo        out  [3:0] {draw_com, draw_user}
//   bad_choice   out  sticky flag: the last press had an invalid choice
//   match_over   out  (MATCH_LIMIT_EN only) sticky flag: match finished

module round_referee #(
    parameter int DEBOUNCE_CYCLES = 250000
`ifdef MATCH_LIMIT_EN
    ,
    parameter logic [7:0] WIN_TARGET = 8'h05
`endif
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       start_n,
    input  logic [1:0] user_choice,
    input  logic [1:0] com_choice,
    input  logic       draw_done,
    output logic       draw_req,
    output logic [1:0] draw_user,
    output logic [1:0] draw_com,
    output logic [7:0] user_score,
    output logic [7:0] com_score,
    output logic       uwin,
    output logic       cwin,
    output logic       equ,
    output logic       round_valid,
    output logic [3:0] combo,
    output logic       bad_choice
`ifdef MATCH_LIMIT_EN
    ,
    output logic       match_over
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ROCK    = 2'b00;
    localparam logic [1:0] SCISSOR = 2'b01;
    localparam logic [1:0] PAPER   = 2'b10;
    localparam logic [1:0] INVALID = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_JUDGE,
        S_DRAW,
        S_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Start key conditioning
    // ------------------------------------------------------------------
    logic [1:0]       sync_ff;
    logic             start_sync;
    logic             deb_level;
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_flip;
    logic             press_evt;
    logic             release_evt;

    assign start_sync = sync_ff[1];

    // The debounced level flips on the edge that completes the run of
    // differing samples, so the press/release events are combinational
    // and line up with that same edge.
    assign deb_flip    = (start_sync != deb_level) && (deb_cnt == CNT_LAST);
    assign press_evt   = deb_flip && !start_sync;
    assign release_evt = deb_flip && start_sync;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values; a blocking = here would chain the two sync stages
    // into one and silently defeat the synchronizer.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff   <= 2'b11;
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            sync_ff <= {sync_ff[0], start_n};
            if (start_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_flip) begin
                deb_cnt   <= '0;
                deb_level <= start_sync;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Judging helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = 8'h99;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic       user_beats;
    logic       com_beats;
    logic       tie;
    logic       choice_bad;
    logic [7:0] user_next;
    logic [7:0] com_next;

    assign user_beats = (draw_user == ROCK    && draw_com == SCISSOR) ||
                        (draw_user == SCISSOR && draw_com == PAPER)   ||
                        (draw_user == PAPER   && draw_com == ROCK);
    assign com_beats  = (draw_com == ROCK    && draw_user == SCISSOR) ||
                        (draw_com == SCISSOR && draw_user == PAPER)   ||
                        (draw_com == PAPER   && draw_user == ROCK);
    assign tie        = (draw_user == draw_com);
    assign choice_bad = (draw_user == INVALID) || (draw_com == INVALID);
    assign user_next  = bcd_inc(user_score);
    assign com_next   = bcd_inc(com_score);

    assign combo = {draw_com, draw_user};

    // ------------------------------------------------------------------
    // Round state machine
    // ------------------------------------------------------------------
    state_t state;
    logic   rel_seen;   // release arrived before HOLD was reached
    logic   press_ok;

`ifdef MATCH_LIMIT_EN
    assign press_ok = press_evt && !match_over;
`else
    assign press_ok = press_evt;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            rel_seen    <= 1'b0;
            draw_req    <= 1'b0;
            draw_user   <= 2'b00;
            draw_com    <= 2'b00;
            user_score  <= 8'h00;
            com_score   <= 8'h00;
            uwin        <= 1'b0;
            cwin        <= 1'b0;
            equ         <= 1'b0;
            round_valid <= 1'b0;
            bad_choice  <= 1'b0;
`ifdef MATCH_LIMIT_EN
            match_over  <= 1'b0;
`endif
        end else begin
            round_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (press_ok) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    draw_user <= user_choice;
                    draw_com  <= com_choice;
                    if (release_evt) rel_seen <= 1'b1;
                    state <= S_JUDGE;
                end
                S_JUDGE: begin
                    if (release_evt) rel_seen <= 1'b1;
                    if (choice_bad) begin
                        bad_choice <= 1'b1;
                        state      <= S_HOLD;
                    end else begin
                        bad_choice  <= 1'b0;
                        round_valid <= 1'b1;
                        uwin        <= user_beats;
                        cwin        <= com_beats;
                        equ         <= tie;
                        if (user_beats) user_score <= user_next;
                        if (com_beats)  com_score  <= com_next;
`ifdef MATCH_LIMIT_EN
                        if ((user_beats && user_next == WIN_TARGET) ||
                            (com_beats  && com_next  == WIN_TARGET)) begin
                            match_over <= 1'b1;
                        end
`endif
                        state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (release_evt) rel_seen <= 1'b1;
                    if (draw_done) begin
                        draw_req <= 1'b0;
                        state    <= S_HOLD;
                    end else begin
                        draw_req <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (rel_seen || release_evt) begin
                        rel_seen <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_referee.sv
// tb_round_referee -- randomized, scoreboard-checked bench for round_referee.
// A short debounce count stands in for the 5 ms filter; all bounce and
// glitch timings are scaled to it. Define MATCH_LIMIT_EN to exercise the
// match-limit build with WIN_TARGET = 8'h02.

module tb_round_referee;

    localparam int DB = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start_n  = 1'b1;
    logic [1:0] user_choice = 2'b00;
    logic [1:0] com_choice  = 2'b00;
    logic       draw_done   = 1'b0;
    logic       draw_req;
    logic [1:0] draw_user;
    logic [1:0] draw_com;
    logic [7:0] user_score;
    logic [7:0] com_score;
    logic       uwin;
    logic       cwin;
    logic       equ;
    logic       round_valid;
    logic [3:0] combo;
    logic       bad_choice;
`ifdef MATCH_LIMIT_EN
    logic       match_over;
`endif

`ifdef MATCH_LIMIT_EN
    round_referee #(.DEBOUNCE_CYCLES(DB), .WIN_TARGET(8'h02)) dut (
`else
    round_referee #(.DEBOUNCE_CYCLES(DB)) dut (
`endif
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .start_n     (start_n),
        .user_choice (user_choice),
        .com_choice  (com_choice),
        .draw_done   (draw_done),
        .draw_req    (draw_req),
        .draw_user   (draw_user),
        .draw_com    (draw_com),
        .user_score  (user_score),
        .com_score   (com_score),
        .uwin        (uwin),
        .cwin        (cwin),
        .equ         (equ),
        .round_valid (round_valid),
        .combo       (combo),
        .bad_choice  (bad_choice)
`ifdef MATCH_LIMIT_EN
        ,
        .match_over  (match_over)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] flags;   // {uwin, cwin, equ}
        logic [7:0] us;
        logic [7:0] cs;
        logic [3:0] combo;
        int         at;      // cycle count at which round_valid is expected
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    int         user_pts = 0;
    int         com_pts  = 0;
    logic [2:0] last_flags = 3'b000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] bcd(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return 8'((m / 10) * 16 + (m % 10));
    endfunction

    // Reference: outcome from the cyclic order rock -> scissor -> paper,
    // where each choice beats the next one.
    function automatic void expect_round(input logic [1:0] u, input logic [1:0] c, input int n);
        exp_t e;
        int   d;
        d = (int'(c) - int'(u) + 3) % 3;
        if (d == 1 && user_pts < 99) user_pts++;
        if (d == 2 && com_pts  < 99) com_pts++;
        e.flags = {d == 1, d == 2, d == 0};
        e.us    = bcd(user_pts);
        e.cs    = bcd(com_pts);
        e.combo = {c, u};
        e.at    = n + DB + 4;
        last_flags = e.flags;
        sb.push_back(e);
    endfunction

    // Monitor: every judged round must match the oldest pending expectation.
    always @(negedge CLOCK_50) begin
        if (reset_n && round_valid === 1'b1) begin
            check("round_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("rv_flags", {uwin, cwin, equ}, mon_e.flags);
                check("rv_user_score", user_score, mon_e.us);
                check("rv_com_score", com_score, mon_e.cs);
                check("rv_combo", combo, mon_e.combo);
                check("rv_latency", cyc, mon_e.at);
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return {2'b00, draw_req, draw_user, draw_com, user_score, com_score,
                uwin, cwin, equ, round_valid, combo, bad_choice};
    endfunction

    task automatic play(input logic [1:0] u, input logic [1:0] c, input bit early);
        int n;
        int k;
        bit valid;
        bit saw;
        @(negedge CLOCK_50);
        user_choice = u;
        com_choice  = c;
        start_n     = 1'b0;
        n           = cyc;
        valid       = (u != 2'b11) && (c != 2'b11);
        if (valid) begin
            expect_round(u, c, n);
            k = 0;
            while (draw_req !== 1'b1 && k < DB + 20) begin
                @(negedge CLOCK_50);
                k++;
            end
            check("draw_req_rise", draw_req, 1);
            check("draw_req_latency", cyc, n + DB + 5);
            if (early) start_n = 1'b1;
            repeat (3) @(negedge CLOCK_50);
            check("draw_req_hold", draw_req, 1);
            draw_done = 1'b1;
            @(negedge CLOCK_50);
            draw_done = 1'b0;
            check("draw_req_fall", draw_req, 0);
        end else begin
            saw = 1'b0;
            repeat (DB + 10) begin
                @(negedge CLOCK_50);
                saw |= draw_req;
            end
            check("bad_choice_set", bad_choice, 1);
            check("no_draw_on_bad", saw, 0);
            check("scores_kept", {user_score, com_score}, {bcd(user_pts), bcd(com_pts)});
            check("flags_kept", {uwin, cwin, equ}, last_flags);
        end
        start_n = 1'b1;
        repeat (DB + 8) @(negedge CLOCK_50);
        if (valid) check("bad_choice_clear", bad_choice, 0);
    endtask

    task automatic user_win();
        logic [1:0] u;
        u = 2'($urandom_range(0, 2));
        play(u, 2'((u + 1) % 3), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        check("reset_outputs_held", all_outs(), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("outputs_after_reset", all_outs(), 0);

`ifdef MATCH_LIMIT_EN
        check("match_over_reset", match_over, 0);
        play(2'b00, 2'b01, 1'b0);
        check("match_over_not_yet", match_over, 0);
        play(2'b10, 2'b00, 1'b0);
        check("match_over_set", match_over, 1);
        begin
            bit saw;
            @(negedge CLOCK_50);
            user_choice = 2'b00;
            com_choice  = 2'b01;
            start_n     = 1'b0;
            saw = 1'b0;
            repeat (DB + 12) begin
                @(negedge CLOCK_50);
                saw |= draw_req;
            end
            start_n = 1'b1;
            check("press_ignored_after_match", saw, 0);
            check("score_frozen", user_score, 8'h02);
            repeat (DB + 8) @(negedge CLOCK_50);
        end
`else
        // Basic outcomes.
        play(2'b00, 2'b01, 1'b0);
        check("first_uwin", {uwin, cwin, equ}, 3'b100);
        check("first_combo", combo, 4'b0100);
        play(2'b10, 2'b10, 1'b0);
        play(2'b01, 2'b00, 1'b0);

        // Nine more user wins take the score from 01 through the carry to 10.
        repeat (9) user_win();
        check("bcd_carry_ten", user_score, 8'h10);

        // Bounce: glitches one cycle short of the filter, then a settle low.
        @(negedge CLOCK_50);
        user_choice = 2'b10;
        com_choice  = 2'b01;
        start_n = 1'b0; repeat (DB - 1) @(negedge CLOCK_50);
        start_n = 1'b1; repeat (DB - 1) @(negedge CLOCK_50);
        start_n = 1'b0; repeat (10) @(negedge CLOCK_50);
        start_n = 1'b1; repeat (10) @(negedge CLOCK_50);
        check("no_round_from_glitch", 32'(round_valid | draw_req), 0);
        play(2'b10, 2'b01, 1'b1);

        // Invalid choices, then a valid press clears the flag.
        play(2'b11, 2'b00, 1'b0);
        play(2'b01, 2'b11, 1'b0);
        play(2'b01, 2'b10, 1'b0);

        // Random rounds, invalid codes included.
        repeat (20) play(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)));

        // Drive the user score to saturation and one past it.
        while (user_pts < 99) user_win();
        check("bcd_reach_99", user_score, 8'h99);
        user_win();
        check("bcd_saturate_99", user_score, 8'h99);

        // Asynchronous reset in the middle of DRAW.
        begin
            int k;
            @(negedge CLOCK_50);
            user_choice = 2'b00;
            com_choice  = 2'b10;
            start_n     = 1'b0;
            expect_round(2'b00, 2'b10, cyc);
            k = 0;
            while (draw_req !== 1'b1 && k < DB + 20) begin
                @(negedge CLOCK_50);
                k++;
            end
            check("draw_before_reset", draw_req, 1);
            #2 reset_n = 1'b0;
            #1 check("async_reset_outputs", all_outs(), 0);
            start_n    = 1'b1;
            user_pts   = 0;
            com_pts    = 0;
            last_flags = 3'b000;
            @(negedge CLOCK_50) draw_done = 1'b1;
            @(negedge CLOCK_50) draw_done = 1'b0;
            repeat (3) @(negedge CLOCK_50);
            reset_n = 1'b1;
            repeat (3) @(negedge CLOCK_50);
            draw_done = 1'b1;
            @(negedge CLOCK_50) draw_done = 1'b0;
            repeat (DB + 8) @(negedge CLOCK_50);
            check("outputs_after_late_done", all_outs(), 0);
        end
        play(2'b01, 2'b10, 1'b0);
        check("score_after_reset", {user_score, com_score}, 16'h0100);
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
